seven_seg_scanner: RTL
======================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have one parameter: DIV_W, default 17, prescaler width; one scan tick every 2^DIV_W clk cycles.
REQ-002 The block SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port data_in, input, 16, four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-005 The block SHALL have port dp_in, input, 4, decimal-point request per digit, 1 = lit.
REQ-006 The block SHALL have port load, input, 1, single-cycle strobe capturing data_in/dp_in.
REQ-007 The block SHALL have port blank_lz, input, 1, level; 1 = suppress leading zeros.
REQ-008 The block SHALL have port an, output, 4, digit anode enables, active-low, one-hot or all-high.
REQ-009 The block SHALL have port seg, output, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port dp, output, 1, decimal point, active-low.
REQ-011 The block SHALL have port frame_done, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-012 The prescaler SHALL be a DIV_W-bit free-running counter, incrementing every clk and wrapping to 0; tick SHALL be high for exactly the one cycle the counter equals all-ones.
REQ-013 The scan FSM SHALL have states D0, D1, D2, D3, advancing D0->D1->D2->D3->D0 only on tick, holding otherwise.
REQ-014 The D3->D0 transition SHALL be the frame boundary; frame_done SHALL pulse in the cycle after that tick.
REQ-015 load SHALL write data_in/dp_in into a pending register and set pend; a later load before the boundary SHALL overwrite pending (last write wins).
REQ-016 At the frame boundary, if pend = 1, pending SHALL copy into the display register and pend SHALL clear; if pend = 0, the display register SHALL hold.
REQ-017 If load coincides with the boundary tick, the display register SHALL take the old pending contents (if pend), the new data SHALL go into pending, and pend SHALL remain 1.
REQ-018 The displayed value SHALL never change mid-frame (tear-free).
REQ-019 In state Dk, an SHALL drive bit k low and the others high (D0 -> 4'b1110, D3 -> 4'b0111).
REQ-020 The hex decoder SHALL use active-low standard patterns, e.g. 0 -> 7'b1000000, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.
REQ-021 With blank_lz = 1, digit 3 SHALL blank if its nibble is 0, digit 2 if nibbles 3..2 are all 0, and digit 1 if nibbles 3..1 are all 0; digit 0 SHALL never blank.
REQ-022 A blanked digit SHALL drive an = 4'b1111, seg = 7'b1111111, and dp = 1, regardless of dp_in.
REQ-023 dp SHALL equal the inverse of the display-register dp bit for the active digit.
REQ-024 an, seg, dp, and frame_done SHALL be registered, with one clk of latency after the state/display update.

Reset
REQ-025 Reset SHALL force: prescaler 0, state D0, display register 0, pending 0, pend 0, an 4'b1111, seg 7'b1111111, dp 1, frame_done 0.
REQ-026 Reset asserted mid-frame SHALL discard pending data; after release, the first registered output SHALL be an 4'b1110, seg 7'b1000000.

Structure
REQ-027 The segment-pattern constants and the FSM state encodings SHALL live in a shared package/include (seg7_defs) reused by other display blocks.
REQ-028 The hex-to-segment decoder SHALL be one combinational sub-module, hex_to_seg7, with 4-bit input and 7-bit active-low output.
REQ-029 The prescaler SHALL drive a clock-enable tick; no derived clock SHALL be generated.

Verification (DIV_W = 4 in simulation, tick every 16 cycles)
REQ-030 Scenario: reset, then no load -> an cycles 1110, 1101, 1011, 0111 every 16 clk, and seg = 7'b1000000 on every digit.
REQ-031 Scenario: load 16'h12AF, dp_in 4'b0100, mid-frame -> old value persists until the boundary; the next frame shows F, A, 2, 1 on D0..D3, with dp low only on D2.
REQ-032 Scenario: blank_lz = 1, load 16'h0005 -> D3, D2, D1 show an 4'b1111; D0 shows seg 7'b0010010. With 16'h0000, D0 shows 0.
REQ-033 Scenario: two loads (16'h1111, then 16'h2222) within one frame -> only 2222 is displayed; 1111 never appears.
REQ-034 Scenario: load 16'h3333 in the same cycle as the boundary tick, with pending = 16'h4444 -> the next frame shows 4444 and the following frame 3333; frame_done pulses once per frame.
REQ-035 Scenario: rst asserted during D2 with pend = 1 -> outputs go to their reset values immediately; after release, the display shows 0000 and the discarded value never appears.

Source files
------------

// File: rtl/seg7_defs.sv
// Shared seven-segment definitions: scan-state encoding, active-low segment
// patterns ({g,f,e,d,c,b,a}) and anode helpers for the display blocks.
package seg7_defs;

  typedef enum logic [1:0] {
    D0 = 2'd0,
    D1 = 2'd1,
    D2 = 2'd2,
    D3 = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Active-low one-hot anode for the given scan position.
  function automatic logic [3:0] an_for(input scan_state_t s);
    logic [3:0] onehot;
    onehot = 4'b0001 << s;
    return ~onehot;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
// Zero latency; purely combinational, no flow control.
module hex_to_seg7
  import seg7_defs::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner with tear-free frame-boundary
// updates and leading-zero blanking; outputs registered one clk after state/display.
module seven_seg_scanner
  import seg7_defs::*;
#(
  parameter int DIV_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  logic [DIV_W-1:0] presc;
  logic             tick;
  logic             boundary;
  scan_state_t      state;

  logic [15:0] pend_data;
  logic [3:0]  pend_dp;
  logic        pend;
  logic [15:0] disp_data;
  logic [3:0]  disp_dp;

  logic [1:0]  idx;
  logic [3:0]  cur_nib;
  logic        cur_dp;
  logic        cur_blank;
  logic [6:0]  cur_seg;
  logic        blank3;
  logic        blank2;
  logic        blank1;

  // Free-running prescaler; tick is a clock enable, not a derived clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else begin
      presc <= presc + DIV_W'(1);
    end
  end

  assign tick     = &presc;
  assign boundary = tick && (state == D3);

  // Pending is written by load; display only changes at the frame boundary,
  // taking the pending value that existed before any coincident load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend      <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else begin
      if (boundary && pend) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pend      <= 1'b1;
      end else if (boundary) begin
        pend      <= 1'b0;
      end
    end
  end

  assign idx = state;

  always_comb begin
    cur_nib = disp_data[3:0];
    case (idx)
      2'd0: cur_nib = disp_data[3:0];
      2'd1: cur_nib = disp_data[7:4];
      2'd2: cur_nib = disp_data[11:8];
      2'd3: cur_nib = disp_data[15:12];
    endcase
  end

  assign cur_dp = disp_dp[idx];

  // Blanking cascades downward from the most significant digit.
  assign blank3 = blank_lz && (disp_data[15:12] == 4'h0);
  assign blank2 = blank3 && (disp_data[11:8] == 4'h0);
  assign blank1 = blank2 && (disp_data[7:4] == 4'h0);

  always_comb begin
    cur_blank = 1'b0;
    case (idx)
      2'd0: cur_blank = 1'b0;
      2'd1: cur_blank = blank1;
      2'd2: cur_blank = blank2;
      2'd3: cur_blank = blank3;
    endcase
  end

  hex_to_seg7 u_dec (
    .hex (cur_nib),
    .seg (cur_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= D0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        case (state)
          D0: state <= D1;
          D1: state <= D2;
          D2: state <= D3;
          D3: state <= D0;
        endcase
      end
      if (cur_blank) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= an_for(state);
        seg <= cur_seg;
        dp  <= ~cur_dp;
      end
    end
  end

endmodule
